// File: rtl/cpu_seq.sv
// Multi-cycle sequencer for a simple core: FETCH/DECODE/EXEC/MEM/WB control, PC and IR.
// Optional performance counters are built when CPU_SEQ_PERF_CNT_EN is defined.
module cpu_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ins,
  input  logic            wren,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            is_halt,
  input  logic            br_taken,
  input  logic [XLEN-1:0] alu_result,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic            trap,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("cpu_seq: XLEN must be 32 or 64");
  end
  if (PC_RESET[1:0] != 2'b00) begin : g_bad_pc_reset
    $error("cpu_seq: PC_RESET must be word aligned");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ins_q;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] br_tgt, pc_inc;
  logic            mis_tgt;

  // Bit 0 of a branch target is dropped; bit 1 still set means a misaligned word target.
  assign br_tgt  = {alu_result[XLEN-1:1], 1'b0};
  assign mis_tgt = br_taken & br_tgt[1];
  assign pc_inc  = pc_q + XLEN'(4);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    trap_d   = trap_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = DECODE;
      end
      DECODE: state_d = is_halt ? HALT : EXEC;
      EXEC:   state_d = (is_load | is_store) ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) state_d = WB;
      end
      WB: begin
        if (mis_tgt) begin
          trap_d  = 1'b1;
          state_d = HALT;
        end else begin
          rf_we   = wren;
          pc_d    = br_taken ? br_tgt : pc_inc;
          state_d = FETCH;
        end
      end
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      ins_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
      if (state_q == FETCH && imem_ack) ins_q <= imem_rdata;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ins       = ins_q;
  assign state     = state_q;
  assign halted    = (state_q == HALT);
  assign trap      = trap_q;

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [XLEN-1:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != IDLE && state_q != HALT) cyc_q <= cyc_q + XLEN'(1);
      if (state_q == WB && state_d == FETCH)  ret_q <= ret_q + XLEN'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instret   = ret_q;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq; the bench plays imem, dmem, decoder and ALU.
module tb_cpu_seq;
  localparam int          XLEN = 32;
  localparam logic [31:0] PCR  = 32'h0000_0100;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_req, imem_ack = 1'b0;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0, ins;
  logic            wren = 1'b0, is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0;
  logic            br_taken = 1'b0;
  logic [XLEN-1:0] alu_result = '0;
  logic            dmem_req, dmem_we, dmem_ack = 1'b0, rf_we;
  logic [XLEN-1:0] pc, cycle_cnt, instret;
  logic [2:0]      state;
  logic            halted, trap;

  int errs = 0;
  int checks = 0;

  cpu_seq #(.XLEN(XLEN), .PC_RESET(PCR)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .wren(wren), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
    .br_taken(br_taken), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .pc(pc), .state(state), .halted(halted), .trap(trap),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait ALU instruction starting in FETCH, ending in the next FETCH.
  task automatic run_alu(input logic [31:0] exp_pc);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    cyc();
    imem_ack = 1'b0; wren = 1'b1; is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0; br_taken = 1'b0;
    cyc(); cyc(); cyc();
    chk("alu_pc", pc, exp_pc);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_state", state, 0);
    chk("rst_pc", pc, PCR);
    chk("rst_ins", ins, 0);
    chk("rst_halted", {halted, trap}, 0);
    chk("rst_req", {imem_req, dmem_req, dmem_we, rf_we}, 0);
    chk("rst_cnt", {cycle_cnt, instret}, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("idle_state", state, 0);
    chk("idle_req", imem_req, 0);

    // ADD, zero-wait fetch
    cyc();
    chk("f1_state", state, 1);
    chk("f1_req", imem_req, 1);
    chk("f1_addr", imem_addr, PCR);
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0093;
    cyc();
    chk("dec_state", state, 2);
    chk("dec_ins", ins, 32'h00A0_0093);
    chk("dec_req", imem_req, 0);
    imem_rdata = 32'hDEAD_BEEF; wren = 1'b1;
    cyc();
    chk("exe_state", state, 3);
    chk("ack_ignored", ins, 32'h00A0_0093);
    chk("exe_rfwe", rf_we, 0);
    cyc();
    chk("wb_state", state, 5);
    chk("wb_rfwe", rf_we, 1);
    imem_ack = 1'b0;
    cyc();
    chk("add_pc", pc, PCR + 4);
    chk("f2_rfwe", rf_we, 0);

    // fetch stalled five cycles, then a load with a 3-cycle dmem ack
    imem_rdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, PCR + 4);
      chk("stall_ins", ins, 32'h00A0_0093);
      cyc();
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_2083; #1;
    chk("stall6_req", imem_req, 1);
    cyc();
    chk("ld_ins", ins, 32'h0000_2083);
    imem_ack = 1'b0; is_load = 1'b1; wren = 1'b1;
    cyc(); cyc();
    chk("mem_state", state, 4);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dmem_ack = 1'b1;
      #1;
      chk("ld_req", {dmem_req, dmem_we}, 2'b10);
      cyc();
    end
    chk("ld_wb_state", state, 5);
    chk("ld_wb_rfwe", rf_we, 1);
    chk("ld_wb_dreq", dmem_req, 0);
    dmem_ack = 1'b0;
    cyc();
    chk("ld_pc", pc, PCR + 8);

    // store, zero-wait
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0; is_load = 1'b0; is_store = 1'b1; wren = 1'b0;
    cyc(); cyc();
    dmem_ack = 1'b1; #1;
    chk("st_req", {dmem_req, dmem_we}, 2'b11);
    cyc();
    chk("st_wb_rfwe", rf_we, 0);
    dmem_ack = 1'b0;
    cyc();
    chk("st_pc", pc, PCR + 12);

    // taken branch to 0x105 -> 0x104
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0; is_store = 1'b0; wren = 1'b1; br_taken = 1'b1; alu_result = 32'h105;
    cyc(); cyc();
    chk("br_wb_rfwe", rf_we, 1);
    cyc();
    chk("br_pc", imem_addr, 32'h104);

    // taken branch to 0x106 traps
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0; alu_result = 32'h106;
    cyc(); cyc();
    chk("mis_rfwe", rf_we, 0);
    cyc();
    chk("mis_state", state, 6);
    chk("mis_flags", {halted, trap}, 2'b11);
    chk("mis_pc", pc, 32'h104);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    cyc(); cyc();
    chk("halt_stays", state, 6);
    chk("halt_req", {imem_req, dmem_req, dmem_we, rf_we}, 0);
    imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;

    // reset during MEM, no clock edge needed
    rst = 1'b0; #1;
    chk("rst2_flags", {halted, trap}, 0);
    @(negedge clk); rst = 1'b1;
    cyc();
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0; is_load = 1'b1;
    cyc(); cyc();
    chk("rmem_req", dmem_req, 1);
    #2; rst = 1'b0; #1;
    chk("rmem_drop", {dmem_req, state}, 0);
    chk("rmem_pc", pc, PCR);
    chk("rmem_ins", ins, 0);
    @(negedge clk); rst = 1'b1; is_load = 1'b0;
    cyc();
    chk("restart_addr", imem_addr, PCR);

    // three ALU instructions then a halt
    run_alu(PCR + 4);
    run_alu(PCR + 8);
    run_alu(PCR + 12);
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0; is_halt = 1'b1;
    cyc();
    chk("hlt_state", state, 6);
    chk("hlt_flags", {halted, trap}, 2'b10);
`ifdef CPU_SEQ_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, 14);
    chk("instret", instret, 3);
`else
    chk("cycle_cnt", cycle_cnt, 0);
    chk("instret", instret, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    errs++;
    $display("FAIL timeout: got running want finished");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "timeout");
  end
endmodule
